// File: rtl/mul_share_sched_pkg.sv
// mul_sched_pkg: shared types and sizing for the shared-multiplier scheduler.
// Holds the FSM state enum, default operand width, lane id width and the
// iteration counter width helper.
package mul_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mulState_e;

   localparam int MUL_WIDTH = 16;
   localparam int MUL_LANES = 2;
   localparam int LANE_W    = 1;

   // Counter must be able to hold the value WIDTH itself, not just WIDTH-1
   function automatic int countWidth(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int MUL_CNT_W = countWidth(MUL_WIDTH);

endpackage

// File: rtl/mul_share_sched_if.sv
// mul_share_sched_if: request/response bundle between the two issue lanes,
// the memory-stage consumer and the shared multiplier scheduler.
// The master modport is the lane/consumer side, slave is the scheduler.
interface mul_share_sched_if
   import mul_sched_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int LANES = MUL_LANES
) ();

   logic [LANES-1:0]  req_valid;
   logic [LANES-1:0]  req_ready;
   logic [WIDTH-1:0]  req_op1_0;
   logic [WIDTH-1:0]  req_op2_0;
   logic [WIDTH-1:0]  req_instr_0;
   logic [WIDTH-1:0]  req_op1_1;
   logic [WIDTH-1:0]  req_op2_1;
   logic [WIDTH-1:0]  req_instr_1;

   logic              resp_valid;
   logic              resp_ready;
   logic [LANE_W-1:0] resp_lane;
   logic [WIDTH-1:0]  resp_result;
   logic [WIDTH-1:0]  resp_instr;

   modport master (
      output req_valid, req_op1_0, req_op2_0, req_instr_0,
             req_op1_1, req_op2_1, req_instr_1, resp_ready,
      input  req_ready, resp_valid, resp_lane, resp_result, resp_instr
   );

   modport slave (
      input  req_valid, req_op1_0, req_op2_0, req_instr_0,
             req_op1_1, req_op2_1, req_instr_1, resp_ready,
      output req_ready, resp_valid, resp_lane, resp_result, resp_instr
   );

endinterface

// File: rtl/mul_share_sched_iter.sv
// mul_iter_core: radix-2 shift-add multiplier datapath, one partial product
// per step. All arithmetic wraps modulo 2^WIDTH.
// Optional macro MUL_EARLY_EXIT_EN: done also asserts once the remaining
// multiplier bits are all zero, shortening the operation.
module mul_iter_core
   import mul_sched_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] op1_i,
   input  logic [WIDTH-1:0] op2_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int CNT_W = countWidth(WIDTH);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Load fresh operands, or add the shifted multiplicand for each set multiplier bit
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      if (load_i) begin
         acc_d    = '0;
         mcand_d  = op1_i;
         mplier_d = op2_i;
         count_d  = '0;
      end else if (step_i) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + CNT_W'(1);
      end
   end

   // Datapath registers; cleared on reset so no stale partial product survives
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
      end
   end

`ifdef MUL_EARLY_EXIT_EN
   assign done_o = (mplier_q == '0) || (count_q == CNT_W'(WIDTH));
`else
   assign done_o = (count_q == CNT_W'(WIDTH));
`endif

   assign product_o = acc_q;

endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one iterative multiplier
// between the two execute lanes. Owns arbitration, the IDLE/BUSY/DONE FSM
// and the response registers; the datapath lives in mul_iter_core.
// Optional macro MUL_EARLY_EXIT_EN (handled inside mul_iter_core).
module mul_share_sched
   import mul_sched_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int LANES = MUL_LANES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   output logic             busy,
   mul_share_sched_if.slave bus
);

   mulState_e         state_q, state_d;
   logic              rrLast_q;
   logic [LANE_W-1:0] respLane_q;
   logic [WIDTH-1:0]  respInstr_q;
   logic [WIDTH-1:0]  respResult_q;

   logic [LANES-1:0]  grant;
   logic              load;
   logic              step;
   logic              finish;
   logic              coreDone;
   logic [WIDTH-1:0]  coreProduct;
   logic [WIDTH-1:0]  selOp1;
   logic [WIDTH-1:0]  selOp2;
   logic [WIDTH-1:0]  selInstr;

   assign selOp1   = grant[1] ? bus.req_op1_1   : bus.req_op1_0;
   assign selOp2   = grant[1] ? bus.req_op2_1   : bus.req_op2_0;
   assign selInstr = grant[1] ? bus.req_instr_1 : bus.req_instr_0;

   // Arbitration and next-state: flush overrides everything, ties go to the lane not served last
   always_comb begin
      state_d = state_q;
      grant   = '0;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!flush) begin
               if (bus.req_valid[0] && (!bus.req_valid[1] || rrLast_q)) begin
                  grant[0] = 1'b1;
               end else if (bus.req_valid[1]) begin
                  grant[1] = 1'b1;
               end
               if (grant != '0) begin
                  load    = 1'b1;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else if (coreDone) begin
               finish  = 1'b1;
               state_d = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE: begin
            if (flush || bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, round-robin pointer and response capture; rrLast starts at 1 so lane 0 wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         rrLast_q     <= 1'b1;
         respLane_q   <= '0;
         respInstr_q  <= '0;
         respResult_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            rrLast_q    <= grant[1];
            respLane_q  <= grant[1];
            respInstr_q <= selInstr;
         end
         if (finish) begin
            respResult_q <= coreProduct;
         end
      end
   end

   mul_iter_core #(
      .WIDTH(WIDTH)
   ) uCore (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load),
      .step_i   (step),
      .op1_i    (selOp1),
      .op2_i    (selOp2),
      .done_o   (coreDone),
      .product_o(coreProduct)
   );

   assign bus.req_ready   = grant;
   assign bus.resp_valid  = (state_q == DONE);
   assign bus.resp_lane   = respLane_q;
   assign bus.resp_result = respResult_q;
   assign bus.resp_instr  = respInstr_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: directed bench for the shared-multiplier scheduler.
// Expected products, latencies and grants are hand-computed constants.
module tb_mul_share_sched;
   import mul_sched_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   logic busy;

   int compared   = 0;
   int mismatched = 0;
   int n;
   logic [15:0] heldResult;

   mul_share_sched_if #(.WIDTH(16), .LANES(2)) bus ();

   mul_share_sched #(
      .WIDTH(16),
      .LANES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .busy (busy),
      .bus  (bus)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Raise one lane's request with its operands and tag
   task automatic applyStimulus(input int lane, input logic [15:0] op1, input logic [15:0] op2,
                                input logic [15:0] instr);
      if (lane == 0) begin
         bus.req_op1_0   = op1;
         bus.req_op2_0   = op2;
         bus.req_instr_0 = instr;
         bus.req_valid[0] = 1'b1;
      end else begin
         bus.req_op1_1   = op1;
         bus.req_op2_1   = op2;
         bus.req_instr_1 = instr;
         bus.req_valid[1] = 1'b1;
      end
   endtask

   task automatic applyReset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
   endtask

   function automatic int expLatency(input logic [15:0] op2);
`ifdef MUL_EARLY_EXIT_EN
      int hi;
      hi = -1;
      for (int i = 0; i < 16; i++) begin
         if (op2[i]) hi = i;
      end
      return (hi < 0) ? 1 : hi + 2;
`else
      return 17;
`endif
   endfunction

   // Tick until resp_valid shows up or the budget runs out; count = edges waited
   task automatic waitResp(input int maxCycles, output int cycles);
      cycles = 0;
      while (!bus.resp_valid && cycles < maxCycles) begin
         tick();
         cycles++;
      end
   endtask

   // One complete single-lane multiply with handshake
   task automatic doOp(input string tag, input int lane, input logic [15:0] op1,
                       input logic [15:0] op2, input logic [15:0] instr, input logic [15:0] expResult);
      int cyc;
      applyStimulus(lane, op1, op2, instr);
      #1;
      checkOutput({tag, " req_ready"}, 32'(bus.req_ready), (lane == 0) ? 32'h1 : 32'h2);
      tick();
      bus.req_valid = 2'b00;
      waitResp(40, cyc);
      checkOutput({tag, " latency"}, 32'(cyc), 32'(expLatency(op2)));
      checkOutput({tag, " result"}, 32'(bus.resp_result), 32'(expResult));
      checkOutput({tag, " lane"}, 32'(bus.resp_lane), 32'(lane));
      checkOutput({tag, " instr"}, 32'(bus.resp_instr), 32'(instr));
      bus.resp_ready = 1'b1;
      tick();
      checkOutput({tag, " resp_valid drop"}, 32'(bus.resp_valid), 32'h0);
      bus.resp_ready = 1'b0;
   endtask

   // Directed sequence
   initial begin
      bus.req_valid   = 2'b00;
      bus.req_op1_0   = '0;
      bus.req_op2_0   = '0;
      bus.req_instr_0 = '0;
      bus.req_op1_1   = '0;
      bus.req_op2_1   = '0;
      bus.req_instr_1 = '0;
      bus.resp_ready  = 1'b0;
      #1;
      checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset resp_result", 32'(bus.resp_result), 32'h0);
      checkOutput("reset resp_instr", 32'(bus.resp_instr), 32'h0);
      checkOutput("reset resp_lane", 32'(bus.resp_lane), 32'h0);
      applyReset();

      $display("[TB] single lane 0");
      doOp("lane0 7x9", 0, 16'h0007, 16'h0009, 16'hA001, 16'h003F);

      $display("[TB] round robin");
      applyReset();
      applyStimulus(0, 16'h0003, 16'h0005, 16'hB000);
      applyStimulus(1, 16'h0010, 16'h0010, 16'hB001);
      bus.resp_ready = 1'b1;
      #1;
      checkOutput("rr first grant", 32'(bus.req_ready), 32'h1);
      tick();
      checkOutput("rr busy no ready", 32'(bus.req_ready), 32'h0);
      checkOutput("rr busy flag", 32'(busy), 32'h1);
      waitResp(40, n);
      checkOutput("rr0 latency", 32'(n), 32'(expLatency(16'h0005)));
      checkOutput("rr0 result", 32'(bus.resp_result), 32'h000F);
      checkOutput("rr0 lane", 32'(bus.resp_lane), 32'h0);
      checkOutput("rr0 instr", 32'(bus.resp_instr), 32'hB000);
      tick();
      checkOutput("rr bubble resp_valid", 32'(bus.resp_valid), 32'h0);
      checkOutput("rr second grant", 32'(bus.req_ready), 32'h2);
      tick();
      waitResp(40, n);
      checkOutput("rr1 latency", 32'(n), 32'(expLatency(16'h0010)));
      checkOutput("rr1 result", 32'(bus.resp_result), 32'h0100);
      checkOutput("rr1 lane", 32'(bus.resp_lane), 32'h1);
      checkOutput("rr1 instr", 32'(bus.resp_instr), 32'hB001);
      tick();
      checkOutput("rr third grant", 32'(bus.req_ready), 32'h1);
      bus.req_valid  = 2'b00;
      bus.resp_ready = 1'b0;
      #1;

      $display("[TB] overflow and zero operands");
      doOp("ovf ffff", 0, 16'hFFFF, 16'hFFFF, 16'hC001, 16'h0001);
      doOp("ovf 8000", 1, 16'h8000, 16'h0002, 16'hC002, 16'h0000);
      doOp("zero op1", 0, 16'h0000, 16'h1234, 16'hC003, 16'h0000);
      doOp("zero op2", 1, 16'h1234, 16'h0000, 16'hC004, 16'h0000);
      doOp("op2 three", 0, 16'h0005, 16'h0003, 16'hF000, 16'h000F);

      $display("[TB] backpressure");
      applyStimulus(0, 16'h0003, 16'h0004, 16'hC100);
      tick();
      bus.req_valid = 2'b00;
      waitResp(40, n);
      checkOutput("bp latency", 32'(n), 32'(expLatency(16'h0004)));
      heldResult = bus.resp_result;
      checkOutput("bp result", 32'(heldResult), 32'h000C);
      bus.req_valid = 2'b11;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp hold valid", 32'(bus.resp_valid), 32'h1);
         checkOutput("bp hold result", 32'(bus.resp_result), 32'h000C);
         checkOutput("bp hold instr", 32'(bus.resp_instr), 32'hC100);
         checkOutput("bp no ready", 32'(bus.req_ready), 32'h0);
         checkOutput("bp busy", 32'(busy), 32'h1);
      end
      bus.req_valid  = 2'b00;
      bus.resp_ready = 1'b1;
      tick();
      checkOutput("bp release valid", 32'(bus.resp_valid), 32'h0);
      checkOutput("bp release busy", 32'(busy), 32'h0);
      tick();
      checkOutput("bp single handshake", 32'(bus.resp_valid), 32'h0);
      bus.resp_ready = 1'b0;

      $display("[TB] flush in busy");
      applyStimulus(1, 16'h0005, 16'h8005, 16'hD001);
      tick();
      bus.req_valid = 2'b00;
      repeat (7) tick();
      checkOutput("flush pre busy", 32'(busy), 32'h1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush busy drop", 32'(busy), 32'h0);
      checkOutput("flush no resp", 32'(bus.resp_valid), 32'h0);
      applyStimulus(0, 16'h0002, 16'h0003, 16'hD100);
      applyStimulus(1, 16'h0009, 16'h0009, 16'hD101);
      #1;
      checkOutput("flush rr kept", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 2'b00;
      waitResp(40, n);
      checkOutput("post flush latency", 32'(n), 32'(expLatency(16'h0003)));
      checkOutput("post flush result", 32'(bus.resp_result), 32'h0006);
      checkOutput("post flush instr", 32'(bus.resp_instr), 32'hD100);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;

      $display("[TB] flush in idle");
      flush = 1'b1;
      applyStimulus(1, 16'h0002, 16'h0002, 16'hD200);
      #1;
      checkOutput("idle flush ready", 32'(bus.req_ready), 32'h0);
      tick();
      checkOutput("idle flush no accept", 32'(busy), 32'h0);
      flush = 1'b0;
      bus.req_valid = 2'b00;
      #1;

      $display("[TB] reset in done");
      applyStimulus(0, 16'h0007, 16'h0009, 16'hE000);
      tick();
      bus.req_valid = 2'b00;
      waitResp(40, n);
      checkOutput("rst pre valid", 32'(bus.resp_valid), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rst async valid", 32'(bus.resp_valid), 32'h0);
      checkOutput("rst async busy", 32'(busy), 32'h0);
      checkOutput("rst async result", 32'(bus.resp_result), 32'h0);
      checkOutput("rst async instr", 32'(bus.resp_instr), 32'h0);
      #1;
      reset = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
